counter_delay_arbiter: RTL and testbench
========================================

// Module: counter_delay_arbiter
// PURPOSE
//  Shares one up-counter datapath between N_REQ requesters that each need a timed delay.
//  A round-robin arbiter grants the counter to one requester at a time and latches that
//  requester's delay value. An FSM clears the counter, runs it to the delay target, and
//  pulses a per-requester done. Sits between local control FSMs and the shared counter.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2)
//  CW     4  counter/delay width; max delay 2**CW-1
// PORTS
//  clk    in   1         single clock, rising edge
//  clr    in   1         synchronous, active-high reset
//  req    in   N_REQ     level request per requester; held until done (or dropped = abort)
//  delay  in   N_REQ*CW  delay[i*CW +: CW] = delay for requester i, sampled at grant
//  gnt    out  N_REQ     one-hot grant, registered; 0 when idle
//  done   out  N_REQ     one-cycle completion pulse, registered
//  busy   out  1         high whenever state != IDLE
//  cnt    out  CW        current shared counter value
// BEHAVIOUR
//  - Reset (clr=1 at edge): state=IDLE, gnt=0, done=0, busy=0, cnt=0, rr_ptr=0, idx=0, tgt=0.
//    clr has priority over every other event. A grant in flight is dropped with no done.
//  - FSM states are IDLE, RUN and DONE.
//  - IDLE: if |req, pick the first set req at or after rr_ptr, wrapping modulo N_REQ.
//    At the same edge: idx<=winner, tgt<=delay[winner], cnt<=0, ->RUN. If no req, stay IDLE.
//  - RUN: gnt=onehot(idx).
//    If req[idx]==0: abort. ->IDLE, rr_ptr<=idx+1 mod N_REQ, no done, cnt holds.
//    Else if cnt==tgt: ->DONE, cnt holds.
//    Else cnt<=cnt+1.
//    RUN lasts exactly tgt+1 cycles. delay==0 gives 1 RUN cycle.
//  - DONE: done[idx]=1 for this one cycle, gnt still onehot(idx).
//    rr_ptr<=idx+1 mod N_REQ, ->IDLE.
//  - Latency: grant edge at cycle k. gnt is visible cycles k..k+tgt+1. done is in cycle k+tgt+1.
//    gnt=0 and busy=0 in cycle k+tgt+2. The earliest next grant takes effect in cycle k+tgt+3.
//  - A requester must drop req in the cycle after done. If it is still high, it is simply
//    re-eligible behind the others (rr_ptr has already moved past it).
//  - Changes to delay[] after grant are ignored (tgt is latched).
//  - cnt never exceeds tgt <= 2**CW-1, so it never wraps.
//  - Unsigned arithmetic throughout. rr_ptr and idx are $clog2(N_REQ) bits, wrap modulo N_REQ.
//  - A req arriving during RUN/DONE waits. Only IDLE arbitrates.
//  - Simultaneous events:
//    - Abort and cnt==tgt in the same cycle: abort wins.
//    - clr together with anything: reset wins.
// STRUCTURE
//  - Package counter_ctrl_pkg holds:
//    - typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_t
//    - localparam default widths
//    - function rr_pick(req, ptr) returning winner index and valid
//  - One sub-module: tick_counter.
//    - Ports: clk, clr, load0 (sync clear), en (increment), q[CW].
//    - It is the shared datapath. The arbiter drives load0/en and exports q as cnt.
//  - All outputs come straight from flops, with no combinational input-to-output path.
// TESTING (N_REQ=4, CW=4)
//  1. clr=1 for 2 cycles, then idle
//     -> gnt=0, done=0, busy=0, cnt=0. gnt stays 0 with req=0.
//  2. req=0010, delay[1]=3, grant edge k
//     -> gnt=0010 for cycles k..k+4. cnt=0,1,2,3,3.
//     -> done=0010 only in cycle k+4. busy=0 in cycle k+5.
//  3. req=1111 held, all delays=0
//     -> grants in order 0001,0010,0100,1000,0001, each lasting 2 cycles, 3-cycle period.
//     -> each done pulse matches its grant.
//  4. req=0100, delay=10, drop req[2] when cnt=5
//     -> gnt=0 the next cycle, no done[2], rr_ptr=3.
//     -> with req=1001 pending, requester 3 is granted next.
//  5. delay[0]=15
//     -> 16 RUN cycles, cnt reaches 15 and never wraps to 0.
//     -> done=0001 in cycle k+16.
//  6. clr pulsed while RUN at cnt=7 for requester 3, req=1001 held
//     -> next cycle all outputs 0 with no done.
//     -> requester 0 is granted first after clr (rr_ptr=0).

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types, default widths and round-robin pick for the delay arbiter
package counter_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_t;

   localparam int N_REQ_DEF = 4;
   localparam int CW_DEF    = 4;

   // Upper bound on requesters the pick function can scan
   localparam int MAX_REQ = 32;
   localparam int MAX_IW  = 5;

   typedef struct packed {
      logic              valid;
      logic [MAX_IW-1:0] idx;
   } pick_t;

   // First set request at or after ptr, wrapping modulo n
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input int unsigned ptr,
                                     input int unsigned n);
      pick_t       p;
      int unsigned j;
      p = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (i < n && !p.valid) begin
            j = ptr + i;
            if (j >= n) j = j - n;
            if (req[j[MAX_IW-1:0]]) begin
               p.valid = 1'b1;
               p.idx   = j[MAX_IW-1:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - shared up-counter datapath with synchronous clear
module tick_counter
   import counter_ctrl_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          load0,
   input  logic          en,
   output logic [CW-1:0] q
);

   // Clear on reset or new grant, otherwise count when enabled
   always_ff @(posedge clk) begin
      if (clr || load0) q <= '0;
      else if (en)      q <= q + CW'(1);
   end

endmodule

// File: rtl/counter_delay_arbiter.sv
// rtl/counter_delay_arbiter.sv - round-robin arbiter sharing one delay counter among requesters
module counter_delay_arbiter
   import counter_ctrl_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*CW-1:0] delay,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic                busy,
   output logic [CW-1:0]       cnt
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   cnt_state_t       state, state_n;
   logic [IW-1:0]    idx, idx_n, rr_ptr, rr_ptr_n, win;
   logic [CW-1:0]    tgt, tgt_n;
   logic [N_REQ-1:0] gnt_n, done_n;
   logic             busy_n, load0, en, win_ok;
   pick_t            pick;

   function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
   endfunction

   assign pick   = rr_pick(MAX_REQ'(req), 32'(rr_ptr), N_REQ);
   assign win_ok = pick.valid && ({1'b0, pick.idx} < 6'(N_REQ));
   assign win    = pick.idx[IW-1:0];

   tick_counter #(.CW(CW)) u_tick (
      .clk   (clk),
      .clr   (clr),
      .load0 (load0),
      .en    (en),
      .q     (cnt)
   );

   // Next state, registered-output values and counter controls
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      tgt_n    = tgt;
      rr_ptr_n = rr_ptr;
      gnt_n    = '0;
      done_n   = '0;
      load0    = 1'b0;
      en       = 1'b0;
      case (state)
         IDLE: begin
            if (win_ok) begin
               state_n = RUN;
               idx_n   = win;
               tgt_n   = delay[int'(win)*CW +: CW];
               load0   = 1'b1;
               gnt_n   = onehot(win);
            end
         end
         RUN: begin
            // Abort takes precedence over reaching the target
            if (!req[idx]) begin
               state_n  = IDLE;
               rr_ptr_n = wrap_inc(idx);
            end else if (cnt == tgt) begin
               state_n = DONE;
               gnt_n   = onehot(idx);
               done_n  = onehot(idx);
            end else begin
               en    = 1'b1;
               gnt_n = onehot(idx);
            end
         end
         DONE: begin
            state_n  = IDLE;
            rr_ptr_n = wrap_inc(idx);
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // State and output registers; clr drops any grant in flight
   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= IDLE;
         idx    <= '0;
         tgt    <= '0;
         rr_ptr <= '0;
         gnt    <= '0;
         done   <= '0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         tgt    <= tgt_n;
         rr_ptr <= rr_ptr_n;
         gnt    <= gnt_n;
         done   <= done_n;
         busy   <= busy_n;
      end
   end

endmodule

// File: tb/tb_counter_delay_arbiter.sv
// tb/tb_counter_delay_arbiter.sv - directed self-checking bench for counter_delay_arbiter
module tb_counter_delay_arbiter;

   logic        clk = 1'b0;
   logic        clr;
   logic [3:0]  req;
   logic [15:0] delay;
   logic [3:0]  gnt, done, cnt;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        clr;
      logic [3:0]  req;
      logic [15:0] delay;
      logic [3:0]  gnt;
      logic [3:0]  done;
      logic        busy;
      logic [3:0]  cnt;
   } vec_t;

   vec_t vecs[$];

   counter_delay_arbiter #(.N_REQ(4), .CW(4)) dut (
      .clk   (clk),
      .clr   (clr),
      .req   (req),
      .delay (delay),
      .gnt   (gnt),
      .done  (done),
      .busy  (busy),
      .cnt   (cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic c, input logic [3:0] r, input logic [15:0] d,
                      input logic [3:0] g, input logic [3:0] dn, input logic b,
                      input logic [3:0] ct);
      vec_t v;
      v.clr = c; v.req = r; v.delay = d; v.gnt = g; v.done = dn; v.busy = b; v.cnt = ct;
      vecs.push_back(v);
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] dn,
                          input logic b, input logic [3:0] ct);
      chk({tag, "_gnt"},  32'(gnt),  32'(g));
      chk({tag, "_done"}, 32'(done), 32'(dn));
      chk({tag, "_busy"}, 32'(busy), 32'(b));
      chk({tag, "_cnt"},  32'(cnt),  32'(ct));
   endtask

   initial begin
      int n;
      logic [3:0] oh;
      clr = 1'b1; req = '0; delay = '0;

      // reset held two cycles, then idle with no requests
      add(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0);
      add(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0);
      // single requester 1 with delay 3
      add(0, 4'b0010, 16'h0030, 4'b0010, 4'b0000, 1, 0);
      add(0, 4'b0010, 16'h0030, 4'b0010, 4'b0000, 1, 1);
      add(0, 4'b0010, 16'h0030, 4'b0010, 4'b0000, 1, 2);
      add(0, 4'b0010, 16'h0030, 4'b0010, 4'b0000, 1, 3);
      add(0, 4'b0010, 16'h0030, 4'b0010, 4'b0010, 1, 3);
      add(0, 4'b0000, 16'h0030, 4'b0000, 4'b0000, 0, 3);
      // re-reset, then all four requesting with zero delay
      add(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0);
      for (int g = 0; g < 5; g++) begin
         oh = 4'b0001 << (g % 4);
         add(0, 4'b1111, 16'h0000, oh,      4'b0000, 1, 0);
         add(0, 4'b1111, 16'h0000, oh,      oh,      1, 0);
         add(0, (g == 4) ? 4'b0000 : 4'b1111, 16'h0000, 4'b0000, 4'b0000, 0, 0);
      end

      foreach (vecs[i]) begin
         clr = vecs[i].clr; req = vecs[i].req; delay = vecs[i].delay;
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].cnt);
      end

      // abort: requester 2 drops at cnt=5; rr_ptr is 1 here so 2 wins
      req = 4'b0100; delay = 16'h0A00;
      step();
      chk_all("ab_grant", 4'b0100, 4'b0000, 1, 0);
      n = 0;
      while (cnt != 4'd5 && n < 20) begin
         step();
         chk("ab_nodone", 32'(done), 32'(0));
         n++;
      end
      chk("ab_reach5", 32'(cnt), 32'(5));
      req = 4'b1001; delay = 16'hCA00;
      step();
      chk_all("ab_drop", 4'b0000, 4'b0000, 0, 5);
      step();
      chk_all("ab_next3", 4'b1000, 4'b0000, 1, 0);

      // clr mid-run for requester 3 at cnt=7
      n = 0;
      while (cnt != 4'd7 && n < 20) begin
         step();
         n++;
      end
      chk("cl_reach7", 32'(cnt), 32'(7));
      clr = 1'b1;
      step();
      chk_all("cl_reset", 4'b0000, 4'b0000, 0, 0);

      // max delay on requester 0, granted first after clr
      clr = 1'b0; delay = 16'hCA0F;
      step();
      chk_all("mx_grant", 4'b0001, 4'b0000, 1, 0);
      delay = 16'hCA02;
      for (int i = 1; i < 16; i++) begin
         step();
         chk_all($sformatf("mx_run%0d", i), 4'b0001, 4'b0000, 1, 4'(i));
      end
      step();
      chk_all("mx_done", 4'b0001, 4'b0001, 1, 15);
      req = 4'b0000;
      step();
      chk_all("mx_idle", 4'b0000, 4'b0000, 0, 15);
      step();
      chk_all("mx_stay", 4'b0000, 4'b0000, 0, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
